sram_cache_controller: RTL and testbench

//  2-way set-associative, write-through, no-write-allocate word cache between the MEM stage and SRAMController.

---
 rtl/arm_mem_pkg.sv | 22 ++
 rtl/cache_set_array.sv | 63 ++++++
 rtl/sram_cache_controller.sv | 123 ++++++++++++
 tb/tb_sram_cache_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared constants, FSM encoding and cache-line payload for the MEM-stage word cache.
package arm_mem_pkg;

  localparam int unsigned SETS   = 64;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2
  } cache_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cache_line_t;

endpackage

// File: rtl/cache_set_array.sv
// Two-way tag/data storage with per-set LRU bit; combinational read, synchronous write,
// async clear of valid and lru state.
module cache_set_array
  import arm_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output cache_line_t      rd_line0_o,
  output cache_line_t      rd_line1_o,
  output logic             rd_lru_o,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_en_i,
  input  logic             wr_way_i,
  input  cache_line_t      wr_line_i,
  input  logic             lru_en_i,
  input  logic             lru_val_i
);

  logic [SETS-1:0]   valid0_q;
  logic [SETS-1:0]   valid1_q;
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag0_q  [SETS];
  logic [TAG_W-1:0]  tag1_q  [SETS];
  logic [DATA_W-1:0] data0_q [SETS];
  logic [DATA_W-1:0] data1_q [SETS];

  // Only valid and lru need clearing; tag/data are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (wr_en_i && !wr_way_i) valid0_q[wr_idx_i] <= wr_line_i.valid;
      if (wr_en_i &&  wr_way_i) valid1_q[wr_idx_i] <= wr_line_i.valid;
      if (lru_en_i)             lru_q[wr_idx_i]    <= lru_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      if (wr_way_i) begin
        tag1_q[wr_idx_i]  <= wr_line_i.tag;
        data1_q[wr_idx_i] <= wr_line_i.data;
      end else begin
        tag0_q[wr_idx_i]  <= wr_line_i.tag;
        data0_q[wr_idx_i] <= wr_line_i.data;
      end
    end
  end

  always_comb begin
    rd_line0_o.valid = valid0_q[rd_idx_i];
    rd_line0_o.tag   = tag0_q[rd_idx_i];
    rd_line0_o.data  = data0_q[rd_idx_i];
    rd_line1_o.valid = valid1_q[rd_idx_i];
    rd_line1_o.tag   = tag1_q[rd_idx_i];
    rd_line1_o.data  = data1_q[rd_idx_i];
    rd_lru_o         = lru_q[rd_idx_i];
  end

endmodule

// File: rtl/sram_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate word cache in front of
// the SRAMController; read hits complete in the same cycle, everything else stalls.
module sram_cache_controller
  import arm_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        freeze,
  output logic        sramRead,
  output logic        sramWrite,
  output logic [31:0] sramAddress,
  output logic [31:0] sramDataIn,
  input  logic [31:0] sramDataOut,
  input  logic        sramFreeze
);

  cache_state_e     state_q, state_d;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  cache_line_t      line0, line1, wr_line;
  logic             lru, hit0, hit1, hit, hit_way, victim;
  logic             wr_en, wr_way, lru_en, lru_val;

  assign req_idx = address[IDX_W+1:2];
  assign req_tag = address[ADDR_W-1:IDX_W+2];

  cache_set_array u_set_array (
    .clk        (clk),
    .rst_n      (rst),
    .rd_idx_i   (req_idx),
    .rd_line0_o (line0),
    .rd_line1_o (line1),
    .rd_lru_o   (lru),
    .wr_idx_i   (req_idx),
    .wr_en_i    (wr_en),
    .wr_way_i   (wr_way),
    .wr_line_i  (wr_line),
    .lru_en_i   (lru_en),
    .lru_val_i  (lru_val)
  );

  // Fills only happen on a miss, so at most one way can match.
  always_comb begin
    hit0    = line0.valid && (line0.tag == req_tag);
    hit1    = line1.valid && (line1.tag == req_tag);
    hit     = hit0 || hit1;
    hit_way = hit1;
    if (!line0.valid)      victim = 1'b0;
    else if (!line1.valid) victim = 1'b1;
    else                   victim = lru;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_way  = 1'b0;
    wr_line = '0;
    lru_en  = 1'b0;
    lru_val = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (write) begin
          state_d = ST_WR_THRU;
        end else if (read) begin
          if (hit) begin
            lru_en  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            state_d = ST_RD_MISS;
          end
        end
      end
      ST_RD_MISS: begin
        if (!sramFreeze) begin
          state_d = ST_IDLE;
          wr_en   = 1'b1;
          wr_way  = victim;
          wr_line = '{valid: 1'b1, tag: req_tag, data: sramDataOut};
          lru_en  = 1'b1;
          lru_val = ~victim;
        end
      end
      ST_WR_THRU: begin
        if (!sramFreeze) begin
          state_d = ST_IDLE;
          if (hit) begin
            wr_en   = 1'b1;
            wr_way  = hit_way;
            wr_line = '{valid: 1'b1, tag: req_tag, data: dataIn};
            lru_en  = 1'b1;
            lru_val = ~hit_way;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are gated by reset so a mid-transaction reset drops them at once.
  always_comb begin
    freeze    = rst && ((state_q != ST_IDLE) || write || (read && !hit));
    sramRead  = rst && (state_q == ST_RD_MISS);
    sramWrite = rst && (state_q == ST_WR_THRU);
    dataOut   = '0;
    if (rst && (state_q == ST_IDLE) && read && !write && hit) begin
      dataOut = hit1 ? line1.data : line0.data;
    end
  end

  assign sramAddress = address;
  assign sramDataIn  = dataIn;

endmodule

// File: tb/tb_sram_cache_controller.sv
// Bench for sram_cache_controller: SRAM latency model plus an MRU/LRU recency-list cache model.
module tb_sram_cache_controller;
  import arm_mem_pkg::*;

  localparam int unsigned MEM_WORDS = 1 << (ADDR_W - 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [31:0] address, dataIn, dataOut;
  logic        freeze, sramRead, sramWrite;
  logic [31:0] sramAddress, sramDataIn, sramDataOut;
  logic        sramFreeze;

  always #5 clk = ~clk;

  sram_cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .read        (read),
    .write       (write),
    .address     (address),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .freeze      (freeze),
    .sramRead    (sramRead),
    .sramWrite   (sramWrite),
    .sramAddress (sramAddress),
    .sramDataIn  (sramDataIn),
    .sramDataOut (sramDataOut),
    .sramFreeze  (sramFreeze)
  );

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // SRAM controller model: freeze for sram_lat cycles, then one done cycle.
  int unsigned       sram_lat = 0;
  int unsigned       sram_cnt;
  logic [31:0]       mem     [MEM_WORDS];
  bit                wr_flag [MEM_WORDS];
  logic [ADDR_W-3:0] sram_w;

  assign sram_w      = sramAddress[ADDR_W-1:2];
  assign sramFreeze  = (sramRead || sramWrite) && (sram_cnt < sram_lat);
  assign sramDataOut = wr_flag[sram_w] ? mem[sram_w] : init_word(32'(sram_w));

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_cnt <= 0;
    end else if (sramRead || sramWrite) begin
      if (sram_cnt < sram_lat) begin
        sram_cnt <= sram_cnt + 1;
      end else begin
        sram_cnt <= 0;
        if (sramWrite) begin
          mem[sram_w]     <= sramDataIn;
          wr_flag[sram_w] <= 1'b1;
        end
      end
    end
  end

  // Reference: per-set recency list of up to two tags, plus the expected memory image.
  int unsigned m_cnt [SETS];
  int unsigned m_mru [SETS];
  int unsigned m_lru [SETS];
  logic [31:0] exp_mem [int unsigned];

  function automatic void model_clear();
    for (int i = 0; i < int'(SETS); i++) m_cnt[i] = 0;
  endfunction

  function automatic bit model_has(input int unsigned idx, input int unsigned tag);
    return (m_cnt[idx] >= 1 && m_mru[idx] == tag) || (m_cnt[idx] == 2 && m_lru[idx] == tag);
  endfunction

  function automatic void model_touch(input int unsigned idx, input int unsigned tag);
    if (m_mru[idx] != tag) begin
      m_lru[idx] = m_mru[idx];
      m_mru[idx] = tag;
    end
  endfunction

  function automatic void model_fill(input int unsigned idx, input int unsigned tag);
    m_lru[idx] = m_mru[idx];
    m_mru[idx] = tag;
    if (m_cnt[idx] < 2) m_cnt[idx] = m_cnt[idx] + 1;
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned w);
    return exp_mem.exists(w) ? exp_mem[w] : init_word(w);
  endfunction

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One MEM-stage request, held until the cache releases it; checks stalls, handshake and data.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int unsigned lat);
    int unsigned idx, tag, w, frz, rdc, wrc, n;
    bit hit, done;
    idx = 32'(addr[IDX_W+1:2]);
    tag = 32'(addr[ADDR_W-1:IDX_W+2]);
    w   = 32'(addr[ADDR_W-1:2]);
    hit = model_has(idx, tag);
    frz = 0; rdc = 0; wrc = 0; n = 0; done = 1'b0;
    @(negedge clk);
    sram_lat = lat;
    read = rd; write = wr; address = addr; dataIn = wdata;
    #1;
    if (wr) begin
      while (!done && n < 64) begin
        n++;
        if (freeze)    frz++;
        if (sramRead)  rdc++;
        if (sramWrite) wrc++;
        done = sramWrite && !sramFreeze;
        if (!done) begin @(negedge clk); #1; end
      end
      check("wr_stall", frz, lat + 2);
      check("wr_sram_wr", wrc, lat + 1);
      check("wr_sram_rd", rdc, 0);
      exp_mem[w] = wdata;
      if (hit) model_touch(idx, tag);
    end else begin
      while (freeze && n < 64) begin
        n++;
        frz++;
        if (sramRead)  rdc++;
        if (sramWrite) wrc++;
        @(negedge clk); #1;
      end
      check("rd_stall", frz, hit ? 0 : lat + 2);
      check("rd_sram_rd", rdc, hit ? 0 : lat + 1);
      check("rd_sram_wr", wrc, 0);
      check("rd_idle_req", 32'({sramRead, sramWrite}), 0);
      check("rd_data", dataOut, exp_word(w));
      if (hit) model_touch(idx, tag);
      else     model_fill(idx, tag);
    end
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned op;
    read = 1'b0; write = 1'b0; address = '0; dataIn = '0;
    model_clear();
    rst = 1'b1;
    #2 rst = 1'b0;
    read = 1'b1; address = 32'h0000_0100;
    #1;
    check("rst_freeze", 32'(freeze), 0);
    check("rst_dataout", dataOut, 0);
    check("rst_sram_req", 32'({sramRead, sramWrite}), 0);
    @(negedge clk); @(negedge clk);
    read = 1'b0;
    rst = 1'b1;

    // Cold read miss, then a zero-stall hit.
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3);
    // Store miss is write-through only; later read fetches it from SRAM.
    access(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 1);
    access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0);
    // Two ways of set 0, then an eviction of the LRU way.
    access(1'b1, 1'b0, 32'h0000_0100 + SETS * 4, 32'h0, 1);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2);
    access(1'b1, 1'b0, 32'h0000_0100 + 2 * SETS * 4, 32'h0, 2);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1);
    access(1'b1, 1'b0, 32'h0000_0100 + SETS * 4, 32'h0, 1);
    // Store hit updates the cached word.
    access(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 2);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2);
    // Read and write together behave as a store.
    access(1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 1);
    access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1);

    // Reset in the middle of a read miss.
    @(negedge clk);
    sram_lat = 8;
    read = 1'b1; address = 32'h0000_4300;
    repeat (3) @(negedge clk);
    #1;
    check("mid_sram_rd", 32'(sramRead), 1);
    check("mid_freeze", 32'(freeze), 1);
    rst = 1'b0;
    #1;
    check("rst_mid_freeze", 32'(freeze), 0);
    check("rst_mid_sram_rd", 32'(sramRead), 0);
    check("rst_mid_dataout", dataOut, 0);
    @(negedge clk);
    read = 1'b0;
    rst = 1'b1;
    model_clear();
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1);

    // Random traffic over a few sets and tags to exercise hits, misses and evictions.
    for (int i = 0; i < 250; i++) begin
      a = ($urandom() & 32'hFFF8_0003)
        | (32'($urandom_range(0, 4)) << (IDX_W + 2))
        | (32'($urandom_range(0, 3)) << 2);
      op = $urandom_range(0, 9);
      if (op < 6)      access(1'b1, 1'b0, a, 32'h0, $urandom_range(0, 3));
      else if (op < 9) access(1'b0, 1'b1, a, $urandom(), $urandom_range(0, 3));
      else             access(1'b1, 1'b1, a, $urandom(), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
